// File: rtl/cim_pkg.sv
// Shared CIM constants: bit-serial index width, last-bit indices and frame widths.
package cim_pkg;

   localparam int SEL_W       = 6;
   localparam int LAST_12     = 11;
   localparam int LAST_24     = 23;
   localparam int PSUM_W_DFLT = 10;

   typedef enum logic {
      W12 = 1'b0,
      W24 = 1'b1
   } frame_w_e;

   function automatic logic [4:0] last_idx(input frame_w_e fw);
      return (fw == W24) ? 5'(LAST_24) : 5'(LAST_12);
   endfunction

endpackage

// File: rtl/bs_out_reg.sv
// Single-entry valid/ready holding register; a load into an occupied, stalled
// register is dropped and flagged on the sticky o_ovf.
module bs_out_reg #(
   parameter int DATA_W = 35
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_ovf
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_ovf;
   logic              w_xfer;
   logic              w_stall;

   assign w_xfer  = r_valid & i_ready;
   assign w_stall = r_valid & ~i_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (i_load) begin
            // A load in the same cycle as a completed transfer replaces the entry.
            if (w_stall) begin
               r_ovf <= 1'b1;
            end else begin
               r_data  <= i_data;
               r_valid <= 1'b1;
            end
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/bs_accum.sv
// Bit-serial shift-accumulator: weights each psum by 2^sel and emits the frame sum.
// Define SIGNED_IN_EN to treat the MSB bit-plane as negatively weighted (signed input).
module bs_accum
   import cim_pkg::*;
#(
   parameter int PSUM_W = cim_pkg::PSUM_W_DFLT,
   parameter int ACC_W  = PSUM_W + 25
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              inwidth,
   input  logic              st,
   input  logic [SEL_W-1:0]  sel,
   input  logic [PSUM_W-1:0] psum,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ovf,
   output logic              seq_err
);

   logic signed [ACC_W-1:0] r_acc;
   logic [SEL_W-1:0]        r_exp_sel;
   logic [4:0]              r_last;
   logic                    r_active;
   logic                    r_seq_err;

   logic signed [PSUM_W-1:0] w_psum;
   logic signed [ACC_W-1:0]  w_psum_ext;
   logic signed [ACC_W-1:0]  w_term;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_final;
   logic                     w_start;
   logic                     w_bad_st;
   logic                     w_in_seq;
   logic                     w_final_bit;
   logic                     w_mid;
   logic                     w_break;

   assign w_psum     = psum;
   assign w_psum_ext = ACC_W'(w_psum);
   assign w_term     = w_psum_ext <<< sel;
   assign w_sum      = r_acc + w_term;

`ifdef SIGNED_IN_EN
   assign w_final = r_acc - w_term;
`else
   assign w_final = w_sum;
`endif

   assign w_start     = st & (sel == '0);
   assign w_bad_st    = st & (sel != '0);
   assign w_in_seq    = r_active & ~st & (sel == r_exp_sel);
   assign w_final_bit = w_in_seq & (sel == {1'b0, r_last});
   assign w_mid       = w_in_seq & ~w_final_bit;
   assign w_break     = r_active & ~st & (sel != r_exp_sel);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_acc     <= '0;
         r_exp_sel <= '0;
         r_last    <= '0;
         r_active  <= 1'b0;
         r_seq_err <= 1'b0;
      end else begin
         if (w_start) begin
            // A start always wins; an unfinished frame is abandoned and flagged.
            if (r_active && (r_exp_sel != '0))
               r_seq_err <= 1'b1;
            r_last    <= last_idx(frame_w_e'(inwidth));
            r_acc     <= w_psum_ext;
            r_exp_sel <= SEL_W'(1);
            r_active  <= 1'b1;
         end else if (w_bad_st) begin
            r_seq_err <= 1'b1;
         end else if (w_mid) begin
            r_acc     <= w_sum;
            r_exp_sel <= r_exp_sel + SEL_W'(1);
         end else if (w_final_bit) begin
            r_active <= 1'b0;
         end else if (w_break) begin
            r_seq_err <= 1'b1;
            r_active  <= 1'b0;
         end
      end
   end

   // Output stage: result registered one cycle after the final bit is sampled.
   bs_out_reg #(
      .DATA_W (ACC_W)
   ) u_out_reg (
      .clk     (clk),
      .rstn    (rstn),
      .i_load  (w_final_bit),
      .i_data  (w_final),
      .i_ready (out_ready),
      .o_data  (out_data),
      .o_valid (out_valid),
      .o_ovf   (ovf)
   );

   assign seq_err = r_seq_err;

endmodule

// File: doc/bs_accum.md
Name: bs_accum

Overview:
- Bit-serial shift-accumulator. It is the consumer of the `sel`/`st` sequence that the global controller emits over each bit-serial input frame.
- Each cycle it takes one signed partial sum from the CIM macro adder tree, weights it by 2^sel and accumulates it.
- At the final bit it emits the full-precision dot-product result over a valid/ready output port to the post-processing stage.
- Supports 12-bit frames (`inwidth`=0, sel 0..11) and 24-bit frames (`inwidth`=1, sel 0..23).

Parameters:
- PSUM_W, 10, width of signed partial-sum input per bit cycle.
- ACC_W, PSUM_W+25, signed accumulator/result width; covers the 24-bit weighting plus one guard bit.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- inwidth  input  1  frame length select: 0 = 12 bits, 1 = 24 bits.
- st  input  1  frame-start strobe from controller; high while sel==0.
- sel  input  6  current bit index from controller.
- psum  input  PSUM_W  signed partial sum for bit `sel`.
- out_data  output  ACC_W  signed accumulated result.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- ovf  output  1  sticky: a result was dropped because the output register was still occupied.
- seq_err  output  1  sticky: sel sequence broke inside a frame.

Behaviour:
- Reset, asynchronous, active low, may occur mid-frame:
  - acc=0, last=0, active=0, out_data=0, out_valid=0, ovf=0, seq_err=0.
  - Any frame in progress is discarded; no partial result is emitted.
- Internal state:
  - acc[ACC_W]: running sum.
  - exp_sel[6]: next expected index.
  - last[5]: final bit index, 11 or 23.
  - active: inside a frame.
- Frame start, detected when st=1 and sel=0:
  - last <= inwidth ? 23 : 11. inwidth is captured here only; changes mid-frame are ignored.
  - acc <= sext(psum); exp_sel <= 1; active <= 1.
  - A start overrides any frame in progress. If active=1 and exp_sel!=0 at that point, seq_err <= 1 and the partial frame is dropped.
- Middle bit, when active=1, st=0 and sel==exp_sel<last:
  - acc <= acc + (sext(psum) << sel); exp_sel <= exp_sel+1.
- Final bit, when active=1, st=0 and sel==last:
  - Final value = acc + w·(sext(psum) << last), where w=-1 with SIGNED_IN_EN defined and w=+1 otherwise.
  - The final value is written to the output register per the handshake rules below; active <= 0.
- Sequence error, when active=1, st=0 and sel!=exp_sel:
  - seq_err <= 1, active <= 0, acc unchanged. The module resyncs at the next frame start.
- Ignored input: st=1 with sel!=0 sets seq_err. When active=0, non-start cycles are ignored.
- Latency: out_valid rises the cycle after the final-bit edge, i.e. result registered 1 cycle after sel==last is sampled.
- Output handshake:
  - A transfer completes when out_valid=1 and out_ready=1; out_valid then drops unless a new result loads in the same cycle.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - Final bit while out_valid=1 and out_ready=0: the new result is dropped and ovf <= 1. The old result is held.
  - Final bit in the same cycle as a completed transfer: the new result loads and out_valid stays 1, with no ovf.
- Arithmetic:
  - All sums are two's complement at ACC_W bits.
  - psum is sign-extended to ACC_W before shifting.
  - No saturation; ACC_W is sized so that no overflow is possible.
- Back-to-back frames: after sel==last the controller's next cycle is st=1, sel=0. The new frame starts with no bubble required.

Optional Feature:
- Macro: SIGNED_IN_EN.
- Defined: the input activation is two's complement. The MSB bit-plane (sel==last) carries weight -2^last and is subtracted.
- Undefined: the input is unsigned. All bit-planes, including sel==last, are added.
- psum is signed in both cases.

Decomposition:
- Shared package cim_pkg holds:
  - SEL_W=6.
  - LAST_12=11, LAST_24=23.
  - PSUM_W default.
  - Enum for the controller frame widths (W12, W24).
- gctrl should also be updated to use these constants.
- One natural sub-module: bs_out_reg, the single-entry valid/ready output holding register that generates the ovf drop. The accumulator datapath stays in the top.

Test Plan:
- Unsigned 12-bit, SIGNED_IN_EN off:
  - Stimulus: inwidth=0, psum=1 on every sel 0..11, out_ready=1.
  - Response: out_data=4095 and out_valid pulses 1 cycle after sel=11.
- Signed 12-bit, SIGNED_IN_EN on:
  - Stimulus: psum=1 on all bits.
  - Response: out_data=-1.
  - Stimulus: psum=-3 only at sel=0, 0 elsewhere.
  - Response: out_data=-3.
- 24-bit frame, signed:
  - Stimulus: inwidth=1, psum=511 at sel=23, 0 elsewhere.
  - Response: out_data=-511·2^23. Then a back-to-back 12-bit frame with psum=2 at sel=5 gives out_data=64.
- Backpressure:
  - Stimulus: out_ready=0 across two consecutive 12-bit frames.
  - Response: the first result is held, the second is dropped and ovf=1. Raising out_ready transfers the first result and then out_valid=0.
- Sequence error:
  - Stimulus: sel jumps 3→5 mid-frame.
  - Response: seq_err=1 and no out_valid for that frame. The next st/sel=0 frame completes correctly.
- Reset mid-frame:
  - Stimulus: rstn low at sel=6.
  - Response: all outputs 0 immediately. A full frame after release yields the correct result.
